// File: rtl/alu_mc_if.sv
// alu_mc_if: operand-issue and result-return bundle for alu_mc.
//   Input side : in_valid, in_ready, op, a, b
//   Output side: out_valid, out_ready, result, zero, carry, overflow
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. The producer holds its payload stable while valid=1 and ready=0;
// valid never waits on ready. The block drives the input ready and the
// output valid/payload.
// Modports: master = decode/writeback side, slave = the ALU.
interface alu_mc_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU with valid/ready on input and output.
// Ops: 000 OR, 001 AND, 010 ADD, 011 SUB, 100 SLT, 101 SLL, 110 SRL, 111 MUL.
// Every op except MUL is computed at the accept edge, so its result is valid in
// the following cycle. MUL is an iterative shift-add that takes WIDTH cycles.
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   bus         slave modport of alu_mc_if (handshakes, operands, result, flags)
//   o_dbg_state out  current FSM state (IDLE=0, MUL=1, DONE=2)
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_mc_if.slave    bus,
  output logic [1:0] o_dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_OR  = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [2*WIDTH-1:0] r_mcand;   // multiplicand, shifted left once per step
  logic [2*WIDTH-1:0] r_acc;     // product accumulator
  logic [WIDTH-1:0]   r_mplier;  // multiplier, LSB is the current bit
  logic [SHW-1:0]     r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_carry;
  logic               r_ovf;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_is_sub;
  logic [WIDTH-1:0]   w_b_op;
  logic [WIDTH:0]     w_sum;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;
  logic [2*WIDTH-1:0] w_acc_next;

  // Ready depends only on state and out_ready, never on in_valid.
  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_ovf;
  assign o_dbg_state   = r_state;

  // Single-cycle datapath on the incoming operands.
  always_comb begin
    w_is_sub = (bus.op == OP_SUB);
    // SUB is a + ~b + 1, so the carry-out means a >= b unsigned.
    w_b_op   = w_is_sub ? ~bus.b : bus.b;
    w_sum    = {1'b0, bus.a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};
    w_shamt  = bus.b[SHW-1:0];
    w_res    = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    case (bus.op)
      OP_OR:  w_res = bus.a | bus.b;
      OP_AND: w_res = bus.a & bus.b;
      OP_ADD, OP_SUB: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        // Overflow: both addends share a sign that the sum does not.
        w_ovf   = (bus.a[WIDTH-1] == w_b_op[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLL: w_res = bus.a << w_shamt;
      OP_SRL: w_res = bus.a >> w_shamt;
      default: w_res = '0;
    endcase
  end

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (bus.op == OP_MUL) begin
              r_state  <= S_MUL;
              r_mcand  <= {{WIDTH{1'b0}}, bus.a};
              r_mplier <= bus.b;
              r_acc    <= '0;
              r_cnt    <= SHW'(WIDTH - 1);
            end else begin
              r_state  <= S_DONE;
              r_result <= w_res;
              r_zero   <= (w_res == '0);
              r_carry  <= w_carry;
              r_ovf    <= w_ovf;
            end
          end else if ((r_state == S_DONE) && bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - SHW'(1);
          if (r_cnt == '0) begin
            // Last multiplier bit folded in this cycle; publish the product.
            r_state  <= S_DONE;
            r_result <= w_acc_next[WIDTH-1:0];
            r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
            r_carry  <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_ovf    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  localparam int W = 32;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // expected {overflow, carry, zero, result}
  logic [W+2:0] exp_q[$];

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the op definitions.
  function automatic logic [W+2:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         c;
    logic         v;
    longint       sa;
    longint       sb;
    longint       s;
    logic [63:0]  p;
    int           sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b % W);
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      3'd0: r = a | b;
      3'd1: r = a & b;
      3'd2: begin
        r = a + b;
        p = 64'(a) + 64'(b);
        c = (p > 64'h0000_0000_FFFF_FFFF);
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd3: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd4: r = (sa < sb) ? 1 : 0;
      3'd5: r = a << sh;
      3'd6: r = a >> sh;
      default: begin
        p = 64'(a) * 64'(b);
        r = p[W-1:0];
        c = (p[63:W] != 0);
      end
    endcase
    return {v, c, (r == 0), r};
  endfunction

  task automatic cmp_out(input string tag);
    logic [W+2:0] e;
    chk({tag, ".q_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, ".result"},   64'(bus.result),   64'(e[W-1:0]));
      chk({tag, ".zero"},     64'(bus.zero),     64'(e[W]));
      chk({tag, ".carry"},    64'(bus.carry),    64'(e[W+1]));
      chk({tag, ".overflow"}, 64'(bus.overflow), 64'(e[W+2]));
    end
  endtask

  // ---------------- driver ----------------
  // Entered and left at posedge+1. Issues one op with out_ready=1, waits for
  // its result and checks it. lat = edges after the accept edge until out_valid.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int lat, output bit rdy_low);
    int n;
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, ".accept_in_time"}, 64'(n < 200), 64'd1);
    exp_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat     = 0;
    rdy_low = 1'b1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) rdy_low = 1'b0;
      @(posedge clk); #1; lat++;
    end
    chk({tag, ".result_in_time"}, 64'(lat < 200), 64'd1);
    cmp_out(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int           lat;
    bit           rdy_low;
    bit           stray;
    logic [W-1:0] held;
    logic [2:0]   s_op[8];
    logic [W-1:0] s_b[8];
    logic [2:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset.in_ready",  64'(bus.in_ready),  64'd1);
    chk("reset.result",    64'(bus.result),    64'd0);
    chk("reset.flags",     64'({bus.zero, bus.carry, bus.overflow}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with signed overflow; result visible right after the accept edge.
    do_op("add_ovf", 3'd2, 32'h7FFF_FFFF, 32'd1, lat, rdy_low);
    chk("add_ovf.latency", 64'(lat), 64'd0);
    chk("add_ovf.result_const", 64'(bus.result), 64'h8000_0000);
    chk("add_ovf.ovf_const", 64'(bus.overflow), 64'd1);

    do_op("sub_eq", 3'd3, 32'd5, 32'd5, lat, rdy_low);
    chk("sub_eq.zero_const",  64'(bus.zero),  64'd1);
    chk("sub_eq.carry_const", 64'(bus.carry), 64'd1);

    do_op("slt_neg", 3'd4, 32'hFFFF_FFFF, 32'd0, lat, rdy_low);
    chk("slt_neg.result_const", 64'(bus.result), 64'd1);

    do_op("mul_hi", 3'd7, 32'h0001_0000, 32'h0001_0000, lat, rdy_low);
    chk("mul_hi.carry_const", 64'(bus.carry), 64'd1);
    chk("mul_hi.latency", 64'(lat), 64'(W));

    // Result valid in the 33rd cycle counting the accept cycle as the first.
    do_op("mul_small", 3'd7, 32'd1234, 32'd5678, lat, rdy_low);
    chk("mul_small.result_const", 64'(bus.result), 64'd7006652);
    chk("mul_small.latency", 64'(lat + 1), 64'd33);
    chk("mul_small.in_ready_low", 64'(rdy_low), 64'd1);

    // Backpressure on an OR result.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = 3'd0;
    bus.a         = 32'hF0F0_0000;
    bus.b         = 32'h0000_0F0F;
    exp_q.push_back(model(3'd0, 32'hF0F0_0000, 32'h0000_0F0F));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp.out_valid", 64'(bus.out_valid), 64'd1);
    held = bus.result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.stable",    64'(bus.result),    64'(held));
      chk("bp.in_ready",  64'(bus.in_ready),  64'd0);
      chk("bp.valid_hold", 64'(bus.out_valid), 64'd1);
    end
    cmp_out("bp");
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp.drained", 64'(bus.out_valid), 64'd0);

    // Streaming: one accept and one result per cycle.
    s_op = '{3'd1, 3'd5, 3'd6, 3'd0, 3'd2, 3'd3, 3'd4, 3'd1};
    for (int i = 0; i < 8; i++) s_b[i] = $urandom;
    s_b[1] = 32'd4;
    s_b[2] = 32'd36;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = s_op[i];
      bus.a        = $urandom;
      bus.b        = s_b[i];
      chk("stream.in_ready", 64'(bus.in_ready), 64'd1);
      exp_q.push_back(model(bus.op, bus.a, bus.b));
      @(posedge clk); #1;
      chk("stream.out_valid", 64'(bus.out_valid), 64'd1);
      cmp_out("stream");
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream.idle_after", 64'(bus.out_valid), 64'd0);

    // Randomised ops against the model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 4 == 0) ? 32'($urandom_range(0, 70)) : $urandom;
      do_op("rand", rop, ra, rb, lat, rdy_low);
      chk("rand.latency", 64'(lat), (rop == 3'd7) ? 64'(W) : 64'd0);
    end
    @(posedge clk); #1;

    // Reset in the middle of a MUL: no result may appear afterwards.
    bus.in_valid = 1'b1;
    bus.op       = 3'd7;
    bus.a        = 32'd77;
    bus.b        = 32'd99;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("rst_mid.in_mul_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid.result",    64'(bus.result),    64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid.in_ready", 64'(bus.in_ready), 64'd1);
    stray = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) stray = 1'b1;
    end
    chk("rst_mid.no_stray", 64'(stray), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule
